sl_fifo_sched: RTL and testbench
================================

SL_FIFO_SCHED -- requirements
Module: sl_fifo_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, words per full FX3 slave-FIFO burst (>=2).
REQ-002 SHALL have parameter TURNAROUND, default 2, cycles from SL_AD change to first strobe (>=1).
REQ-003 SHALL have parameter RD_LATENCY, default 2, cycles from SL_RD_N low to valid SL_DT.
REQ-004 SHALL have parameter PKT_TIMEOUT, default 1024, idle cycles before a short DF2U packet is sent.
REQ-005 SHALL have parameters AD_CU2F=2'b00, AD_DU2F=2'b01, AD_DF2U=2'b11, the FX3 socket addresses.
REQ-006 SYS_CLK  in  1  sole clock; all logic on rising edge.
REQ-007 SYS_RST_N  in  1  asynchronous active-low reset.
REQ-008 FLAG_CU2F / FLAG_DU2F  in  1 each  FX3 command / data socket holds >=BURST_LEN words (pre-synchronized).
REQ-009 FLAG_DF2U  in  1  FX3 out socket has room for >=BURST_LEN words.
REQ-010 CU2F_ROOM, DU2F_ROOM  in  16 each  free words in local command/data receive FIFOs.
REQ-011 DF2U_ITEMS  in  16  words held in local transmit FIFO.
REQ-012 SL_AD  out  2;  SL_RD_N, SL_OE_N, SL_WR_N, SL_PKTEND_N  out  1 each  FX3 slave-FIFO controls.
REQ-013 CAPTURE  out  1  SL_DT valid this cycle; CAP_SEL  out  1  0=command FIFO, 1=data FIFO.
REQ-014 DF2U_POP  out  1  pop transmit FIFO; data drives SL_DT this cycle.
REQ-015 GRANT  out  3  one-hot {DF2U,DU2F,CU2F} for the active burst; BUSY  out  1  FSM not IDLE.

Function
REQ-016 FSM states: IDLE, ADDR, RD, RD_FLUSH, WR, GAP.
REQ-017 Eligibility in IDLE: CU2F = FLAG_CU2F & CU2F_ROOM>=BURST_LEN; DU2F = FLAG_DU2F & DU2F_ROOM>=BURST_LEN; DF2U = FLAG_DF2U & (DF2U_ITEMS>=BURST_LEN | short-packet condition, REQ-031).
REQ-018 Arbitration SHALL be round-robin in order CU2F->DU2F->DF2U, search starting after last granted channel; after reset start at CU2F.
REQ-019 On grant: register GRANT, drive SL_AD, latch LEN (BURST_LEN, or DF2U_ITEMS for short packet), go ADDR.
REQ-020 ADDR SHALL last exactly TURNAROUND cycles, then RD (CU2F/DU2F) or WR (DF2U).
REQ-021 SL_OE_N SHALL be low from ADDR entry through end of RD_FLUSH for read grants only.
REQ-022 RD: SL_RD_N low exactly BURST_LEN consecutive cycles, then RD_FLUSH for RD_LATENCY cycles.
REQ-023 CAPTURE SHALL equal ~SL_RD_N delayed RD_LATENCY cycles; exactly BURST_LEN pulses per read burst; CAP_SEL = GRANT[1].
REQ-024 WR: SL_WR_N low and DF2U_POP high together for exactly LEN cycles.
REQ-025 GAP: one cycle, all strobes high, SL_AD held, then IDLE; earliest next grant the cycle after.
REQ-026 Flags and room inputs SHALL be sampled only in IDLE; flag deassertion mid-burst SHALL NOT shorten the burst.
REQ-027 Grant-to-first-strobe latency = TURNAROUND+1 cycles from IDLE decision edge.
REQ-028 No channel eligible -> remain IDLE, outputs at reset values, GRANT=0.
REQ-029 Width: LEN and internal counters 16 bits; DF2U_ITEMS=0 SHALL never be eligible.

Reset
REQ-030 While SYS_RST_N low: state IDLE, SL_AD=2'b00, all *_N=1, CAPTURE=0, DF2U_POP=0, GRANT=0, BUSY=0, timeout counter=0, RR pointer=CU2F; mid-burst assertion aborts immediately with these values.

Configuration
REQ-031 With SL_SCHED_PKTEND_EN defined: a 16-bit timer counts while 0<DF2U_ITEMS<BURST_LEN and DF2U not granted, clears otherwise; at PKT_TIMEOUT DF2U becomes eligible with LEN=DF2U_ITEMS, and SL_PKTEND_N goes low on the last WR cycle of that packet.
REQ-032 Without SL_SCHED_PKTEND_EN: no timer, only full BURST_LEN writes, SL_PKTEND_N constant 1.

Verification
REQ-033 FLAG_CU2F=1, CU2F_ROOM=64, others idle -> SL_AD=00, 2 ADDR cycles, 16 SL_RD_N lows, 16 CAPTURE pulses starting 2 cycles later, CAP_SEL=0, GAP, IDLE.
REQ-034 All three eligible continuously -> grant sequence CU2F, DU2F, DF2U, CU2F; one GAP cycle between bursts.
REQ-035 DU2F_ROOM=15 with FLAG_DU2F=1 -> no grant; raise to 16 -> grant next IDLE cycle.
REQ-036 PKTEND_EN: DF2U_ITEMS=5, FLAG_DF2U=1, 1024 idle cycles -> 5 WR/POP cycles, SL_PKTEND_N low on 5th; without macro -> no write, PKTEND_N stays 1.
REQ-037 SYS_RST_N low at 8th RD cycle -> all strobes high, BUSY=0 asynchronously; after release first grant is CU2F.

Source files
------------

// File: rtl/sl_fifo_sched.sv
// sl_fifo_sched: round-robin burst scheduler for the CU2F/DU2F/DF2U sockets of an FX3 slave FIFO.
// Defining SL_SCHED_PKTEND_EN adds a timed short-packet flush of DF2U terminated with SL_PKTEND_N.
module sl_fifo_sched #(
  parameter int         BURST_LEN   = 16,
  parameter int         TURNAROUND  = 2,
  parameter int         RD_LATENCY  = 2,
  parameter int         PKT_TIMEOUT = 1024,
  parameter logic [1:0] AD_CU2F     = 2'b00,
  parameter logic [1:0] AD_DU2F     = 2'b01,
  parameter logic [1:0] AD_DF2U     = 2'b11
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST_N,
  input  logic        FLAG_CU2F,
  input  logic        FLAG_DU2F,
  input  logic        FLAG_DF2U,
  input  logic [15:0] CU2F_ROOM,
  input  logic [15:0] DU2F_ROOM,
  input  logic [15:0] DF2U_ITEMS,
  output logic [1:0]  SL_AD,
  output logic        SL_RD_N,
  output logic        SL_OE_N,
  output logic        SL_WR_N,
  output logic        SL_PKTEND_N,
  output logic        CAPTURE,
  output logic        CAP_SEL,
  output logic        DF2U_POP,
  output logic [2:0]  GRANT,
  output logic        BUSY
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_RD       = 3'd2;
  localparam logic [2:0] S_RD_FLUSH = 3'd3;
  localparam logic [2:0] S_WR       = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  localparam logic [15:0] BL  = 16'(BURST_LEN);
  localparam logic [15:0] TA  = 16'(TURNAROUND);
  localparam logic [15:0] RDL = 16'(RD_LATENCY);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_len;
  logic        r_short;
  logic [2:0]  r_grant;
  logic [1:0]  r_ad;
  logic        r_rd_n;
  logic        r_oe_n;
  logic        r_wr_n;
  logic        r_pop;
  logic        r_pktend_n;
  logic [1:0]  r_rr_ptr;

  logic [2:0]  w_elig;
  logic        w_any;
  logic        w_df2u_full;
  logic        w_short_ok;
  logic [1:0]  w_pick;
  logic [2:0]  w_gnt_onehot;
  logic [1:0]  w_gnt_ad;
  logic        w_gnt_short;
  logic [15:0] w_gnt_len;
  logic [1:0]  w_rr_next;

  assign w_df2u_full = (DF2U_ITEMS >= BL);
  assign w_elig[0]   = FLAG_CU2F && (CU2F_ROOM >= BL);
  assign w_elig[1]   = FLAG_DU2F && (DU2F_ROOM >= BL);
  assign w_elig[2]   = FLAG_DF2U && (w_df2u_full || w_short_ok);
  assign w_any       = |w_elig;

`ifdef SL_SCHED_PKTEND_EN
  localparam logic [15:0] PKT_TO = 16'(PKT_TIMEOUT);

  logic [15:0] r_to_cnt;
  logic        w_short_pend;

  // A partial packet waiting in the transmit FIFO ages until it is flushed; saturates at the threshold.
  assign w_short_pend = (DF2U_ITEMS != 16'd0) && !w_df2u_full;

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_to_cnt <= '0;
    end else if (w_short_pend && !r_grant[2]) begin
      if (r_to_cnt < PKT_TO) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_short_ok = w_short_pend && (r_to_cnt >= PKT_TO);
`else
  assign w_short_ok = 1'b0;
`endif

  // Search order rotates so the channel after the last grant is examined first.
  always_comb begin
    w_pick = 2'd0;
    case (r_rr_ptr)
      2'd1:    w_pick = w_elig[1] ? 2'd1 : (w_elig[2] ? 2'd2 : 2'd0);
      2'd2:    w_pick = w_elig[2] ? 2'd2 : (w_elig[0] ? 2'd0 : 2'd1);
      default: w_pick = w_elig[0] ? 2'd0 : (w_elig[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    w_gnt_onehot = 3'b001;
    w_gnt_ad     = AD_CU2F;
    case (w_pick)
      2'd1: begin
        w_gnt_onehot = 3'b010;
        w_gnt_ad     = AD_DU2F;
      end
      2'd2: begin
        w_gnt_onehot = 3'b100;
        w_gnt_ad     = AD_DF2U;
      end
      default: begin
        w_gnt_onehot = 3'b001;
        w_gnt_ad     = AD_CU2F;
      end
    endcase
  end

  assign w_gnt_short = (w_pick == 2'd2) && !w_df2u_full;
  assign w_gnt_len   = w_gnt_short ? DF2U_ITEMS : BL;
  assign w_rr_next   = (w_pick == 2'd2) ? 2'd0 : (w_pick + 2'd1);

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_short    <= 1'b0;
      r_grant    <= 3'b000;
      r_ad       <= 2'b00;
      r_rd_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_pop      <= 1'b0;
      r_pktend_n <= 1'b1;
      r_rr_ptr   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant  <= w_gnt_onehot;
            r_ad     <= w_gnt_ad;
            r_len    <= w_gnt_len;
            r_short  <= w_gnt_short;
            r_rr_ptr <= w_rr_next;
            r_oe_n   <= (w_pick == 2'd2);
            r_cnt    <= 16'd1;
            r_state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (r_cnt >= TA) begin
            r_cnt <= 16'd1;
            if (r_grant[2]) begin
              r_state    <= S_WR;
              r_wr_n     <= 1'b0;
              r_pop      <= 1'b1;
              r_pktend_n <= ~(r_short && (r_len == 16'd1));
            end else begin
              r_state <= S_RD;
              r_rd_n  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RD: begin
          if (r_cnt == r_len) begin
            r_rd_n  <= 1'b1;
            r_cnt   <= 16'd1;
            r_state <= S_RD_FLUSH;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RD_FLUSH: begin
          // OE stays asserted until the last in-flight word has been captured.
          if (r_cnt >= RDL) begin
            r_oe_n  <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WR: begin
          if (r_cnt == r_len) begin
            r_wr_n     <= 1'b1;
            r_pop      <= 1'b0;
            r_pktend_n <= 1'b1;
            r_state    <= S_GAP;
          end else begin
            r_cnt      <= r_cnt + 16'd1;
            r_pktend_n <= ~(r_short && ((r_cnt + 16'd1) == r_len));
          end
        end
        S_GAP: begin
          r_grant <= 3'b000;
          r_ad    <= 2'b00;
          r_short <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read-strobe delay line: tap RD_LATENCY marks the cycle SL_DT carries valid data.
  logic [RD_LATENCY:0] w_cap_tap;
  assign w_cap_tap[0] = ~r_rd_n;

  generate
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_cap_stage
      logic r_tap;
      always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
          r_tap <= 1'b0;
        end else begin
          r_tap <= w_cap_tap[gi];
        end
      end
      assign w_cap_tap[gi+1] = r_tap;
    end
  endgenerate

  assign CAPTURE     = w_cap_tap[RD_LATENCY];
  assign CAP_SEL     = r_grant[1];
  assign SL_AD       = r_ad;
  assign SL_RD_N     = r_rd_n;
  assign SL_OE_N     = r_oe_n;
  assign SL_WR_N     = r_wr_n;
  assign SL_PKTEND_N = r_pktend_n;
  assign DF2U_POP    = r_pop;
  assign GRANT       = r_grant;
  assign BUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_sl_fifo_sched.sv
// Scoreboard bench for sl_fifo_sched: a negedge monitor condenses each burst into a record,
// tasks push expected records when driving stimulus and compare them as bursts complete.
`timescale 1ns/1ps
module tb_sl_fifo_sched;

  localparam int BL  = 16;
  localparam int TA  = 2;
  localparam int RDL = 2;
  localparam int PTO = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_cu2f = 1'b0, flag_du2f = 1'b0, flag_df2u = 1'b0;
  logic [15:0] cu2f_room = '0, du2f_room = '0, df2u_items = '0;
  logic [1:0]  sl_ad;
  logic        sl_rd_n, sl_oe_n, sl_wr_n, sl_pktend_n;
  logic        capture, cap_sel, df2u_pop, busy;
  logic [2:0]  grant;

  always #5 clk = ~clk;

  sl_fifo_sched #(
    .BURST_LEN(BL), .TURNAROUND(TA), .RD_LATENCY(RDL), .PKT_TIMEOUT(PTO),
    .AD_CU2F(2'b00), .AD_DU2F(2'b01), .AD_DF2U(2'b11)
  ) dut (
    .SYS_CLK(clk), .SYS_RST_N(rst_n),
    .FLAG_CU2F(flag_cu2f), .FLAG_DU2F(flag_du2f), .FLAG_DF2U(flag_df2u),
    .CU2F_ROOM(cu2f_room), .DU2F_ROOM(du2f_room), .DF2U_ITEMS(df2u_items),
    .SL_AD(sl_ad), .SL_RD_N(sl_rd_n), .SL_OE_N(sl_oe_n), .SL_WR_N(sl_wr_n),
    .SL_PKTEND_N(sl_pktend_n), .CAPTURE(capture), .CAP_SEL(cap_sel),
    .DF2U_POP(df2u_pop), .GRANT(grant), .BUSY(busy)
  );

  typedef struct packed {
    logic [2:0] grant;
    logic [1:0] ad;
    logic [7:0] addr_cyc;
    logic [7:0] rd_lows;
    logic [7:0] caps;
    logic [7:0] cap_delay;
    logic [7:0] wr_lows;
    logic [7:0] pops;
    logic [7:0] pktend_idx;
    logic [7:0] pktend_cnt;
    logic [7:0] oe_lows;
    logic [7:0] busy_cyc;
    logic       hold_bad;
  } burst_t;

  burst_t exp_q[$];
  burst_t obs_q[$];
  int     idle_q[$];
  int     n_checks = 0;
  int     n_pass = 0;

  function automatic string fmt(burst_t b);
    return $sformatf("g=%b ad=%b addr=%0d rd=%0d cap=%0d capdly=%0d wr=%0d pop=%0d pkidx=%0d pkcnt=%0d oe=%0d busy=%0d hold_bad=%0d",
                     b.grant, b.ad, b.addr_cyc, b.rd_lows, b.caps, b.cap_delay, b.wr_lows,
                     b.pops, b.pktend_idx, b.pktend_cnt, b.oe_lows, b.busy_cyc, b.hold_bad);
  endfunction

  function automatic burst_t exp_read(logic [2:0] g, logic [1:0] a);
    burst_t b = '0;
    b.grant = g; b.ad = a; b.addr_cyc = 8'(TA);
    b.rd_lows = 8'(BL); b.caps = 8'(BL); b.cap_delay = 8'(RDL);
    b.oe_lows = 8'(TA + BL + RDL); b.busy_cyc = 8'(TA + BL + RDL + 1);
    return b;
  endfunction

  function automatic burst_t exp_write(int len, bit short_pkt);
    burst_t b = '0;
    b.grant = 3'b100; b.ad = 2'b11; b.addr_cyc = 8'(TA);
    b.wr_lows = 8'(len); b.pops = 8'(len);
    b.pktend_idx = short_pkt ? 8'(len) : 8'd0;
    b.pktend_cnt = short_pkt ? 8'd1 : 8'd0;
    b.busy_cyc = 8'(TA + len + 1);
    return b;
  endfunction

  // Monitor: one record per completed burst; bursts cut short by reset are discarded.
  burst_t mon_cur;
  logic   mon_prev = 1'b0;
  bit     mon_strobe;
  int     mon_cyc, mon_first_rd, mon_idle = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0;
      mon_idle = 0;
    end else begin
      if (busy && !mon_prev) begin
        mon_cur = '0; mon_cur.grant = grant; mon_cur.ad = sl_ad;
        mon_strobe = 0; mon_cyc = 0; mon_first_rd = 0;
        idle_q.push_back(mon_idle);
      end
      if (busy) begin
        mon_cyc++;
        mon_cur.busy_cyc = mon_cur.busy_cyc + 8'd1;
        if (!sl_rd_n || !sl_wr_n) mon_strobe = 1;
        if (!mon_strobe) mon_cur.addr_cyc = mon_cur.addr_cyc + 8'd1;
        if (!sl_rd_n) begin
          if (mon_cur.rd_lows == 8'd0) mon_first_rd = mon_cyc;
          mon_cur.rd_lows = mon_cur.rd_lows + 8'd1;
        end
        if (capture) begin
          if (mon_cur.caps == 8'd0) mon_cur.cap_delay = 8'(mon_cyc - mon_first_rd);
          mon_cur.caps = mon_cur.caps + 8'd1;
          if (cap_sel !== mon_cur.grant[1]) mon_cur.hold_bad = 1'b1;
        end
        if (!sl_wr_n) mon_cur.wr_lows = mon_cur.wr_lows + 8'd1;
        if (df2u_pop) mon_cur.pops = mon_cur.pops + 8'd1;
        if (!sl_pktend_n) begin
          mon_cur.pktend_cnt = mon_cur.pktend_cnt + 8'd1;
          mon_cur.pktend_idx = mon_cur.wr_lows;
        end
        if (!sl_oe_n) mon_cur.oe_lows = mon_cur.oe_lows + 8'd1;
        if (sl_ad !== mon_cur.ad || grant !== mon_cur.grant) mon_cur.hold_bad = 1'b1;
      end
      if (!busy && mon_prev) begin
        obs_q.push_back(mon_cur);
        mon_idle = 1;
      end else if (!busy) begin
        mon_idle++;
      end
      mon_prev = busy;
    end
  end

  task automatic wait_record(input int budget, output burst_t r, output bit ok);
    ok = 0; r = '0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() > 0) begin
        r = obs_q.pop_front(); ok = 1; break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_busy(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b1) begin
        ok = 1; break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic clear_inputs();
    flag_cu2f = 0; flag_du2f = 0; flag_df2u = 0;
    cu2f_room = 0; du2f_room = 0; df2u_items = 0;
  endtask

  task automatic test_reset();
    bit bad;
    rst_n = 0; flag_cu2f = 1; cu2f_room = 16'd64;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({sl_ad, sl_rd_n, sl_oe_n, sl_wr_n, sl_pktend_n, capture, df2u_pop, grant, busy} !== 12'b00_1111_00_000_0)
      $display("FAIL reset_outputs: got ad=%b rd=%b oe=%b wr=%b pk=%b cap=%b pop=%b g=%b busy=%b, want reset values",
               sl_ad, sl_rd_n, sl_oe_n, sl_wr_n, sl_pktend_n, capture, df2u_pop, grant, busy);
    else n_pass++;
    clear_inputs();
    @(posedge clk); #1; rst_n = 1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || grant !== 3'b000 || sl_rd_n !== 1'b1 || sl_wr_n !== 1'b1) bad = 1;
    end
    n_checks++;
    if (bad) $display("FAIL idle_no_grant: got activity with no channel eligible, want IDLE with GRANT=000");
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    burst_t o, e;
    bit ok;
    int rises;
    logic prev;
    exp_q.delete(); obs_q.delete(); idle_q.delete();
    @(posedge clk); #1;
    flag_cu2f = 1; cu2f_room = 16'd64;
    flag_du2f = 1; du2f_room = 16'd64;
    flag_df2u = 1; df2u_items = 16'd40;
    exp_q.push_back(exp_read(3'b001, 2'b00));
    exp_q.push_back(exp_read(3'b010, 2'b01));
    exp_q.push_back(exp_write(BL, 0));
    exp_q.push_back(exp_read(3'b001, 2'b00));
    rises = 0; prev = busy;
    for (int i = 0; i < 400 && rises < 4; i++) begin
      @(negedge clk); #1;
      if (busy && !prev) rises++;
      prev = busy;
    end
    clear_inputs();
    n_checks++;
    if (rises != 4) $display("FAIL rr_bursts_started: got %0d want 4", rises); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      wait_record(100, o, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) $display("FAIL rr_burst%0d: got timeout want %s", k, fmt(e));
      else if (o !== e) $display("FAIL rr_burst%0d: got %s want %s", k, fmt(o), fmt(e));
      else n_pass++;
      $display("rr burst %0d: %s", k, fmt(o));
    end
    for (int k = 1; k < 4; k++) begin
      n_checks++;
      if (idle_q.size() <= k) $display("FAIL rr_gap%0d: got no burst want idle 1", k);
      else if (idle_q[k] != 1) $display("FAIL rr_gap%0d: got idle %0d want 1", k, idle_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_cu2f_burst();
    burst_t o, e;
    bit ok;
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
    flag_cu2f = 1; cu2f_room = 16'd64;
    exp_q.push_back(exp_read(3'b001, 2'b00));
    wait_busy(50, ok);
    n_checks++;
    if (!ok) $display("FAIL cu2f_start: got busy=%b want 1", busy); else n_pass++;
    // Flag and room fall during the burst; it must still run to full length.
    flag_cu2f = 0; cu2f_room = 0;
    wait_record(100, o, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok) $display("FAIL cu2f_burst: got timeout want %s", fmt(e));
    else if (o !== e) $display("FAIL cu2f_burst: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
    $display("cu2f burst: %s", fmt(o));
  endtask

  task automatic test_room_boundary();
    burst_t o, e;
    bit ok, seen;
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
    flag_du2f = 1; du2f_room = 16'd15;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    n_checks++;
    if (seen) $display("FAIL du2f_room15: got grant want none"); else n_pass++;
    @(posedge clk); #1;
    du2f_room = 16'd16;
    exp_q.push_back(exp_read(3'b010, 2'b01));
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1 || grant !== 3'b010)
      $display("FAIL du2f_room16: got busy=%b grant=%b want busy=1 grant=010", busy, grant);
    else n_pass++;
    flag_du2f = 0; du2f_room = 0;
    wait_record(100, o, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok) $display("FAIL du2f_burst: got timeout want %s", fmt(e));
    else if (o !== e) $display("FAIL du2f_burst: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
    $display("du2f burst: %s", fmt(o));
  endtask

  task automatic test_pktend();
    bit seen;
`ifdef SL_SCHED_PKTEND_EN
    burst_t o, e;
    bit ok;
`else
    bit pk_seen;
`endif
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
    flag_df2u = 1; df2u_items = 16'd5;
`ifdef SL_SCHED_PKTEND_EN
    exp_q.push_back(exp_write(5, 1));
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    n_checks++;
    if (seen) $display("FAIL pkt_early: got grant before timeout want none"); else n_pass++;
    @(negedge clk); #1;
    wait_busy(100, ok);
    n_checks++;
    if (!ok) $display("FAIL pkt_timeout: got busy=%b want 1 after timeout", busy); else n_pass++;
    flag_df2u = 0; df2u_items = 0;
    wait_record(100, o, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok) $display("FAIL pkt_short: got timeout want %s", fmt(e));
    else if (o !== e) $display("FAIL pkt_short: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
    $display("short packet: %s", fmt(o));
`else
    seen = 0; pk_seen = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
      if (!sl_pktend_n) pk_seen = 1;
    end
    n_checks++;
    if (seen) $display("FAIL pkt_disabled: got write of partial packet want none"); else n_pass++;
    n_checks++;
    if (pk_seen) $display("FAIL pktend_const: got SL_PKTEND_N low want constant 1"); else n_pass++;
    flag_df2u = 0; df2u_items = 0;
    $display("short packet held (feature disabled)");
`endif
  endtask

  task automatic test_reset_midburst();
    burst_t o, e;
    bit ok, found;
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
    flag_cu2f = 1; cu2f_room = 16'd64;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!sl_rd_n) begin
        found = 1; break;
      end
    end
    n_checks++;
    if (!found) $display("FAIL mid_rd_start: got no read strobe want one"); else n_pass++;
    repeat (7) @(posedge clk);
    #1; rst_n = 0; #1;
    n_checks++;
    if ({sl_ad, sl_rd_n, sl_oe_n, sl_wr_n, sl_pktend_n, capture, df2u_pop, grant, busy} !== 12'b00_1111_00_000_0)
      $display("FAIL mid_reset_abort: got ad=%b rd=%b oe=%b wr=%b pk=%b cap=%b pop=%b g=%b busy=%b, want reset values",
               sl_ad, sl_rd_n, sl_oe_n, sl_wr_n, sl_pktend_n, capture, df2u_pop, grant, busy);
    else n_pass++;
    flag_du2f = 1; du2f_room = 16'd64;
    flag_df2u = 1; df2u_items = 16'd40;
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    exp_q.push_back(exp_read(3'b001, 2'b00));
    wait_busy(20, ok);
    n_checks++;
    if (!ok || grant !== 3'b001) $display("FAIL post_reset_grant: got %b want 001", grant); else n_pass++;
    clear_inputs();
    wait_record(100, o, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok) $display("FAIL post_reset_burst: got timeout want %s", fmt(e));
    else if (o !== e) $display("FAIL post_reset_burst: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
    $display("post-reset burst: %s", fmt(o));
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_cu2f_burst();
    test_room_boundary();
    test_pktend();
    test_reset_midburst();
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
